// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock. sout_valid marks frame bits and sof marks the first bit.
// Optional feature: define PISO_TX_PARITY_EN to append one even-parity bit
// after the data bits of every frame.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             busy
);

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
`ifdef PISO_TX_PARITY_EN
    // Count value while the last data bit is on sout; the parity bit follows.
    localparam logic [CNT_W-1:0] CNT_PAR = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    // r_sr holds only the bits not yet sent, with the next one at the output
    // end. The first bit goes straight to r_sout at accept, so every bit of
    // r_sr is consumed before it is shifted away.
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_sof;
    logic             r_busy;
`ifdef PISO_TX_PARITY_EN
    logic             r_par;
`endif

    logic             w_accept;
    logic             w_last;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_sr_load;
    logic [WIDTH-1:0] w_sr_shift;

    genvar gi;

    // Bit-order dependent load and shift paths of the shift register.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign w_first_bit = din[WIDTH-1];
            assign w_next_bit  = r_sr[WIDTH-1];
            for (gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi == 0) begin : g_end
                    assign w_sr_load[gi]  = 1'b0;
                    assign w_sr_shift[gi] = 1'b0;
                end else begin : g_mid
                    assign w_sr_load[gi]  = din[gi-1];
                    assign w_sr_shift[gi] = r_sr[gi-1];
                end
            end
        end else begin : g_lsb
            assign w_first_bit = din[0];
            assign w_next_bit  = r_sr[0];
            for (gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi == WIDTH - 1) begin : g_end
                    assign w_sr_load[gi]  = 1'b0;
                    assign w_sr_shift[gi] = 1'b0;
                end else begin : g_mid
                    assign w_sr_load[gi]  = din[gi+1];
                    assign w_sr_shift[gi] = r_sr[gi+1];
                end
            end
        end
    endgenerate

    // Ready in IDLE, or on the last frame bit so a new frame follows with no gap.
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
    assign din_ready = (r_state == S_IDLE) || w_last;
    assign w_accept  = din_valid && din_ready;

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign sof        = r_sof;
    assign busy       = r_busy;

    // Frame FSM: load on accept, shift while in SHIFT, return to IDLE after the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_sof        <= 1'b0;
            r_busy       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else if (w_accept) begin
            // Accept is only possible in IDLE or on the last bit, so the
            // frame in flight is never disturbed by a reload.
            r_state      <= S_SHIFT;
            r_sr         <= w_sr_load;
            r_cnt        <= '0;
            r_sout       <= w_first_bit;
            r_sout_valid <= 1'b1;
            r_sof        <= 1'b1;
            r_busy       <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            r_par        <= ^din;
`endif
        end else if (r_state == S_SHIFT) begin
            if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_sof <= 1'b0;
`ifdef PISO_TX_PARITY_EN
                if (r_cnt == CNT_PAR) begin
                    r_sout <= r_par;
                end else begin
                    r_sout <= w_next_bit;
                    r_sr   <= w_sr_shift;
                end
`else
                r_sout <= w_next_bit;
                r_sr   <= w_sr_shift;
`endif
            end else begin
                r_state      <= S_IDLE;
                r_cnt        <= '0;
                r_sout       <= 1'b0;
                r_sout_valid <= 1'b0;
                r_sof        <= 1'b0;
                r_busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx: one MSB-first and one LSB-first instance share the
// same stimulus. Each instance has a bit-queue reference model fed on accept
// and a monitor that pops and compares on every valid output bit.
// Honours PISO_TX_PARITY_EN in the same way as the design.
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct packed {
        logic b;
        logic f;
    } exp_bit_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         armed = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int MSB = (gi == 0) ? 1 : 0;

            logic ready, so, sv, sf, bsy;
            exp_bit_t exp_q[$];

            piso_tx #(.WIDTH(W), .MSB_FIRST(MSB)) dut (
                .clk       (clk),
                .rst       (rst),
                .din       (din),
                .din_valid (din_valid),
                .din_ready (ready),
                .sout      (so),
                .sout_valid(sv),
                .sof       (sf),
                .busy      (bsy)
            );

            // Reference model: the queue holds the frame bits not yet shown.
            // A new word is taken when nothing of the current frame remains
            // beyond the bit on the wire (the queue is popped mid-cycle).
            always @(posedge clk) begin
                if (rst) begin
                    exp_q.delete();
                end else if (din_valid && exp_q.size() == 0) begin
                    for (int i = 0; i < W; i++) begin
                        exp_bit_t e;
                        e.b = (MSB != 0) ? din[W-1-i] : din[i];
                        e.f = (i == 0);
                        exp_q.push_back(e);
                    end
`ifdef PISO_TX_PARITY_EN
                    begin
                        exp_bit_t p;
                        p.b = ^din;
                        p.f = 1'b0;
                        exp_q.push_back(p);
                    end
`endif
                end
            end

            // Monitor: compare the DUT outputs against the model each cycle.
            always @(negedge clk) begin
                if (armed) begin
                    string tag;
                    tag = (MSB != 0) ? "msb" : "lsb";
                    check1({tag, "_din_ready"}, ready, exp_q.size() <= 1);
                    check1({tag, "_sout_valid"}, sv, exp_q.size() > 0);
                    check1({tag, "_busy"}, bsy, exp_q.size() > 0);
                    if (exp_q.size() > 0) begin
                        exp_bit_t e;
                        e = exp_q.pop_front();
                        check1({tag, "_sout"}, so, e.b);
                        check1({tag, "_sof"}, sf, e.f);
                    end else begin
                        check1({tag, "_sout_idle"}, so, 1'b0);
                        check1({tag, "_sof_idle"}, sf, 1'b0);
                    end
                end
            end
        end
    endgenerate

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        @(posedge clk);
        #1;
        din_valid = v;
        din       = d;
        rst       = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        armed = 1'b1;
        idle(2);

        // Single frames
        drive(1'b1, 8'hA5, 1'b0);
        idle(FL + 3);
        drive(1'b1, 8'h3C, 1'b0);
        idle(FL + 3);

        // Back-to-back: valid held high, second word taken on the last bit
        drive(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < FL; i++) drive(1'b1, 8'h3C, 1'b0);
        idle(FL + 3);

        // Stall protection: din changes while not ready are ignored
        drive(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < FL; i++) drive(1'b1, 8'h00, 1'b0);
        idle(FL + 3);

        // Reset mid-frame, then a clean frame
        drive(1'b1, 8'hA5, 1'b0);
        idle(3);
        drive(1'b0, '0, 1'b1);
        idle(2);
        drive(1'b1, 8'h3C, 1'b0);
        idle(FL + 3);

        // Reset colliding with an accept: word dropped
        drive(1'b1, 8'h81, 1'b1);
        idle(3);

        // Parity-relevant words
        drive(1'b1, 8'h07, 1'b0);
        idle(FL + 3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 99) == 0));
        end
        idle(FL + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
